// File: rtl/map_collision_reader.sv
// rtl/map_collision_reader.sv - map ROM walker returning wall flags for a tile and its four neighbours
module map_collision_reader #(
  parameter logic [10:0] MAP0_BASE  = 11'd0,
  parameter logic [10:0] MAP1_BASE  = 11'd70,
  parameter int          TILE_SHIFT = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic        req_map,
  output logic [10:0] rom_addr,
  input  logic [79:0] rom_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        wall_here,
  output logic        wall_up,
  output logic        wall_down,
  output logic        wall_left,
  output logic        wall_right,
  output logic        resp_oob
);

  localparam logic [6:0] LAST_COL = 7'd79;
  localparam logic [6:0] LAST_ROW = 7'd59;

  typedef enum logic [2:0] {IDLE, RD_UP, RD_MID, RD_DN, RESP} state_t;

  state_t      state;
  logic [6:0]  tx;
  logic [6:0]  ty;
  logic [10:0] base;

  logic [6:0]  req_tx;
  logic [6:0]  req_ty;
  logic [10:0] req_base;
  logic        req_oob;
  logic [10:0] row_addr;
  logic [6:0]  col_here;
  logic [6:0]  col_left;
  logic [6:0]  col_right;

  assign req_tx   = req_x[TILE_SHIFT +: 7];
  assign req_ty   = req_y[TILE_SHIFT +: 7];
  assign req_base = req_map ? MAP1_BASE : MAP0_BASE;
  assign req_oob  = (req_x >= 10'd640) || (req_y >= 10'd480);

  // Column c lives at bit 79-c, so the left neighbour is one bit higher.
  assign row_addr  = base + {4'd0, ty};
  assign col_here  = 7'd79 - tx;
  assign col_left  = 7'd80 - tx;
  assign col_right = 7'd78 - tx;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      tx         <= '0;
      ty         <= '0;
      base       <= '0;
      rom_addr   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      wall_here  <= 1'b0;
      wall_up    <= 1'b0;
      wall_down  <= 1'b0;
      wall_left  <= 1'b0;
      wall_right <= 1'b0;
      resp_oob   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_oob) begin
              wall_here  <= 1'b1;
              wall_up    <= 1'b1;
              wall_down  <= 1'b1;
              wall_left  <= 1'b1;
              wall_right <= 1'b1;
              resp_oob   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              tx       <= req_tx;
              ty       <= req_ty;
              base     <= req_base;
              resp_oob <= 1'b0;
              // Top row has no row above; park on the tile row instead of forming ty-1.
              rom_addr <= (req_ty == 7'd0) ? req_base
                                           : req_base + {4'd0, req_ty} - 11'd1;
              state    <= RD_UP;
            end
          end
        end
        RD_UP: begin
          wall_up  <= (ty == 7'd0) ? 1'b1 : rom_data[col_here];
          rom_addr <= row_addr;
          state    <= RD_MID;
        end
        RD_MID: begin
          wall_here  <= rom_data[col_here];
          wall_left  <= (tx == 7'd0)     ? 1'b1 : rom_data[col_left];
          wall_right <= (tx == LAST_COL) ? 1'b1 : rom_data[col_right];
          rom_addr   <= (ty == LAST_ROW) ? row_addr : row_addr + 11'd1;
          state      <= RD_DN;
        end
        RD_DN: begin
          wall_down  <= (ty == LAST_ROW) ? 1'b1 : rom_data[col_here];
          rom_addr   <= row_addr;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_collision_reader.sv
// tb/tb_map_collision_reader.sv - table-driven and random scoreboard bench for map_collision_reader
module tb_map_collision_reader;

  logic        Clk;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic        req_map;
  logic [10:0] rom_addr;
  logic [79:0] rom_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        wall_here;
  logic        wall_up;
  logic        wall_down;
  logic        wall_left;
  logic        wall_right;
  logic        resp_oob;

  logic [79:0] rom_mem [0:2047];
  assign rom_data = rom_mem[rom_addr];

  map_collision_reader dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_map(req_map),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .wall_here(wall_here), .wall_up(wall_up), .wall_down(wall_down),
    .wall_left(wall_left), .wall_right(wall_right), .resp_oob(resp_oob)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad   = 0;
  logic [5:0]  sb [$];
  logic [10:0] addr_log [0:31];
  int          lat;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        m;
    int          lat;
    logic [10:0] a1;
    logic [10:0] a2;
    logic [10:0] a3;
    logic [5:0]  flags;
    int          stall;
  } vec_t;

  vec_t vecs [0:5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {resp_oob, wall_here, wall_up, wall_down, wall_left, wall_right};
  endfunction

  function automatic logic rom_bit(input int row, input int col);
    logic [79:0] r;
    r = rom_mem[row];
    return r[79 - col];
  endfunction

  // Reference: {oob, here, up, down, left, right}
  function automatic logic [5:0] model(input logic [9:0] x, input logic [9:0] y, input logic m);
    int b, tx, ty;
    logic h, u, d, l, r;
    if (x >= 640 || y >= 480) return 6'b111111;
    b  = m ? 70 : 0;
    tx = int'(x) / 8;
    ty = int'(y) / 8;
    h  = rom_bit(b + ty, tx);
    u  = (ty == 0)  ? 1'b1 : rom_bit(b + ty - 1, tx);
    d  = (ty == 59) ? 1'b1 : rom_bit(b + ty + 1, tx);
    l  = (tx == 0)  ? 1'b1 : rom_bit(b + ty, tx - 1);
    r  = (tx == 79) ? 1'b1 : rom_bit(b + ty, tx + 1);
    return {1'b0, h, u, d, l, r};
  endfunction

  task automatic run_query(input logic [9:0] x, input logic [9:0] y, input logic m,
                           input logic [5:0] exp, input int stall, input logic pre_rdy);
    int n;
    logic [5:0] want;
    req_x = x; req_y = y; req_map = m; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge Clk); #1; n++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    sb.push_back(exp);
    @(posedge Clk); #1;
    req_valid  = 1'b0;
    resp_ready = pre_rdy;
    lat = 1;
    addr_log[1] = rom_addr;
    while (!resp_valid && lat < 20) begin
      @(posedge Clk); #1; lat++;
      if (lat < 32) addr_log[lat] = rom_addr;
    end
    if (!resp_valid) check("resp_timeout", 0, 1);
    want = sb.pop_front();
    check("flags", flags_now(), want);
    if (stall > 0) begin
      resp_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge Clk); #1;
        check("stall_valid", resp_valid, 1);
        check("stall_ready", req_ready, 0);
        check("stall_flags", flags_now(), want);
      end
    end
    resp_ready = 1'b1;
    @(posedge Clk); #1;
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
    check("ready_back", req_ready, 1);
  endtask

  initial begin
    Reset = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_map = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < 2048; i++) rom_mem[i] = '0;
    rom_mem[0]  = {80{1'b1}};
    rom_mem[70] = {80{1'b1}};

    //          x     y   map lat  a1   a2   a3   {oob,h,u,d,l,r} stall
    vecs[0] = '{10'd320, 10'd8,   1'b0, 4, 11'd0,   11'd1,   11'd2,   6'b001000, 0};
    vecs[1] = '{10'd320, 10'd0,   1'b0, 4, 11'd0,   11'd0,   11'd1,   6'b011011, 0};
    vecs[2] = '{10'd320, 10'd8,   1'b1, 4, 11'd70,  11'd71,  11'd72,  6'b001000, 1};
    vecs[3] = '{10'd0,   10'd16,  1'b0, 4, 11'd1,   11'd2,   11'd3,   6'b000010, 0};
    vecs[4] = '{10'd639, 10'd479, 1'b1, 4, 11'd128, 11'd129, 11'd129, 6'b000101, 2};
    vecs[5] = '{10'd700, 10'd100, 1'b0, 1, 11'd129, 11'd0,   11'd0,   6'b111111, 3};

    repeat (3) @(posedge Clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_flags", flags_now(), 0);
    check("rst_rom_addr", rom_addr, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;

    for (int v = 0; v < 6; v++) begin
      run_query(vecs[v].x, vecs[v].y, vecs[v].m, vecs[v].flags, vecs[v].stall, 1'b0);
      check("latency", lat, vecs[v].lat);
      check("addr_c1", addr_log[1], vecs[v].a1);
      if (vecs[v].lat == 4) begin
        check("addr_c2", addr_log[2], vecs[v].a2);
        check("addr_c3", addr_log[3], vecs[v].a3);
        check("addr_resp", rom_addr, vecs[v].a2);
      end
    end

    // Reset during RD_MID drops the query.
    req_x = 10'd320; req_y = 10'd8; req_map = 1'b0; req_valid = 1'b1;
    @(posedge Clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_flags", flags_now(), 0);
    check("midrst_rom_addr", rom_addr, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      check("midrst_no_resp", resp_valid, 0);
    end
    resp_ready = 1'b0;

    for (int i = 0; i < 130; i++)
      rom_mem[i] = {$urandom(), $urandom(), 16'($urandom())};
    for (int q = 0; q < 2000; q++) begin
      logic [9:0] x, y;
      logic m;
      case ($urandom_range(0, 3))
        0: x = 10'($urandom_range(0, 7));
        1: x = 10'($urandom_range(632, 639));
        default: x = 10'($urandom_range(0, 700));
      endcase
      y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(472, 490)) : 10'($urandom_range(0, 500));
      m = 1'($urandom_range(0, 1));
      run_query(x, y, m, model(x, y, m), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
